// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between an ALU result producer/consumer and alu_result_fifo.
// The master side is the environment (producer + consumer); the slave side is the FIFO.
interface alu_result_fifo_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_zero;

    modport master (
        output in_valid, in_result, in_cout, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_zero
    );

    modport slave (
        input  in_valid, in_result, in_cout, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_zero
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for ALU {cout, result} pairs with a sticky drop flag.
// Optional per-entry zero flag is enabled with `define ALU_FIFO_ZFLAG_EN.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_result_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] result;
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    logic   [AW-1:0]    wptr, rptr;
    logic               push, pop;

    // Handshake flags come from the registered count only.
    assign bus.in_ready  = (count != CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid  & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.out_result = mem[rptr].result;
    assign bus.out_cout   = mem[rptr].cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.in_valid && !bus.in_ready) drop_err <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{cout: bus.in_cout, result: bus.in_result};
    end

`ifdef ALU_FIFO_ZFLAG_EN
    logic [DEPTH-1:0] zmem;

    always_ff @(posedge clk) begin
        if (push) zmem[wptr] <= (bus.in_result == '0);
    end

    assign bus.out_zero = bus.out_valid & zmem[rptr];
`else
    assign bus.out_zero = 1'b0;
`endif
endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ALU result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result/Cout on in_result/in_cout is valid.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept an entry this cycle.
REQ-007 SHALL have port in_result  input  WIDTH  ALU result word.
REQ-008 SHALL have port in_cout  input  1  ALU carry-out.
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_result  output  WIDTH  head entry result.
REQ-012 SHALL have port out_cout  output  1  head entry carry.
REQ-013 SHALL have port out_zero  output  1  head entry result is all zeros (see Configuration).
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-015 SHALL have port drop_err  output  1  sticky flag: an input was offered while the FIFO was full.

Function
REQ-016 SHALL push on a rising edge when in_valid=1 and in_ready=1, storing {in_cout, in_result} at the write pointer.
REQ-017 SHALL pop on a rising edge when out_valid=1 and out_ready=1, advancing the read pointer.
REQ-018 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only, and independent of out_ready.
REQ-019 SHALL drive out_valid = (count != 0) and present the head entry combinationally on out_result/out_cout (first-word fall-through).
REQ-020 SHALL make a pushed entry visible on the outputs in the cycle after the push edge, giving one cycle of latency.
REQ-021 SHALL wrap the write and read pointers modulo DEPTH.
REQ-022 SHALL, on a simultaneous push and pop, leave count unchanged and update both pointers.
REQ-023 SHALL, when full with out_ready=1, accept no push in that cycle, because in_ready=0 even though a pop occurs.
REQ-024 SHALL, when empty, pop nothing regardless of out_ready; out_result/out_cout are don't-care while out_valid=0.
REQ-025 SHALL set drop_err on any edge where in_valid=1 and in_ready=0; drop_err SHALL then hold at 1 until reset.
REQ-026 SHALL keep the stored data unchanged when neither a push nor a pop occurs.

Reset
REQ-027 SHALL, on a rising edge with rst_n=0, clear both pointers, count and drop_err, forcing in_ready=1, out_valid=0 and out_zero=0.
REQ-028 SHALL let reset override any push or pop in the same cycle; contents become don't-care.
REQ-029 SHALL, on reset asserted mid-stream, discard all stored entries, so that no stale entry appears after reset releases.

Configuration
REQ-030 SHALL, with macro ALU_FIFO_ZFLAG_EN defined, store a zero bit per entry computed at push time (in_result == 0) and drive out_zero from the head entry, gated by out_valid.
REQ-031 SHALL, without ALU_FIFO_ZFLAG_EN, tie out_zero to 0 and include no storage for the zero bit.

Verification
REQ-032 SHALL cover: reset, then push 0x3C with cout=1 -> next cycle out_valid=1, out_result=0x3C, out_cout=1, count=1.
REQ-033 SHALL cover: push 0x01, 0x02, 0x03, 0x04 with out_ready=0 -> count=4, in_ready=0; then pop 4 -> data order 0x01..0x04 and count=0.
REQ-034 SHALL cover: FIFO full with in_valid=1 and out_ready=1 -> one pop, no push, count=3, drop_err=1 and held until reset.
REQ-035 SHALL cover: continuous simultaneous push/pop over 10 cycles at count=2 -> count stays 2, pointers wrap, data order preserved.
REQ-036 SHALL cover: push 0x00 with ALU_FIFO_ZFLAG_EN defined -> out_zero=1 at the head; push 0x80 -> out_zero=0 when it reaches the head; macro undefined -> out_zero=0 throughout.
REQ-037 SHALL cover: rst_n=0 for one cycle with count=3 -> count=0, out_valid=0, drop_err=0, and the next push appears alone at the head.
